// File: rtl/reset_sequencer_multi.sv
// Power-on reset sequencer: releases NUM_DOMAINS resets in ascending order after PLL lock,
// supports an orderly software re-sequence (descending shutdown) and immediate reassert on PLL loss.
module reset_sequencer_multi #(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLDOFF_CYCLES = 128,
    parameter int STEP_CYCLES    = 32,
    parameter int SYNC_STAGE     = 2
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic [1:0]             last_cause
);

    localparam int CNT_MAX = (HOLDOFF_CYCLES > STEP_CYCLES) ? HOLDOFF_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
    localparam int IDX_W   = $clog2((NUM_DOMAINS > 2) ? NUM_DOMAINS : 2);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_PLL = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLDOFF,
        RELEASE,
        DONE,
        SHUTDOWN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] reset_d;
    logic [1:0]            cause_d;
    logic [SYNC_STAGE-1:0] sync_q;
    logic                  lock_s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGE-1];

    always_comb begin
        // NOTE: every next-value gets a default first so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        reset_d = domain_reset;
        cause_d = last_cause;

        // Lock loss outranks software requests and step events on the same edge.
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            reset_d = '1;
            cause_d = CAUSE_PLL;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = HOLDOFF;
                        cnt_d   = '0;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (IDX_W'(k) == idx_q) reset_d[k] = 1'b0;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (sw_reset_req) begin
                        state_d = SHUTDOWN;
                        idx_d   = IDX_LAST;
                        cnt_d   = '0;
                        cause_d = CAUSE_SW;
                    end
                end
                SHUTDOWN: begin
                    if (cnt_q == STEP_LAST) begin
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (IDX_W'(k) == idx_q) reset_d[k] = 1'b1;
                        end
                        cnt_d = '0;
                        idx_d = idx_q - IDX_W'(1);
                        // Asserting domain 0 ends the shutdown and restarts the hold-off.
                        if (idx_q == '0) state_d = HOLDOFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    reset_d = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            idx_q        <= '0;
            domain_reset <= '1;
            last_cause   <= CAUSE_POR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            domain_reset <= reset_d;
            last_cause   <= cause_d;
        end
    end

    assign seq_busy = (state_q == HOLDOFF) || (state_q == RELEASE) || (state_q == SHUTDOWN);
    assign seq_done = (state_q == DONE);

endmodule

// File: tb/tb_reset_sequencer_multi.sv
// Bench for reset_sequencer_multi: a timeline-based reference model queues expected output
// changes per edge, and a negedge monitor compares every observed change against the queue.
module tb_reset_sequencer_multi;

    localparam int N  = 3;
    localparam int H  = 128;
    localparam int S  = 32;
    localparam int SY = 2;
    localparam int VW = N + 4;

    localparam logic [N-1:0]  ALL_ON    = '1;
    localparam logic [VW-1:0] RESET_VEC = {ALL_ON, 1'b0, 1'b0, 2'b00};

    logic clk           = 1'b0;
    logic async_reset_n = 1'b1;
    logic pll_locked    = 1'b0;
    logic sw_reset_req  = 1'b0;
    logic sw_reset_req2 = 1'b0;

    logic [N-1:0] domain_reset;
    logic         seq_busy, seq_done;
    logic [1:0]   last_cause;
    logic [0:0]   domain_reset2;
    logic         seq_busy2, seq_done2;
    logic [1:0]   last_cause2;

    always #5 clk = ~clk;

    reset_sequencer_multi #(
        .NUM_DOMAINS(N), .HOLDOFF_CYCLES(H), .STEP_CYCLES(S), .SYNC_STAGE(SY)
    ) dut (
        .clk(clk), .async_reset_n(async_reset_n), .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req), .domain_reset(domain_reset),
        .seq_busy(seq_busy), .seq_done(seq_done), .last_cause(last_cause)
    );

    reset_sequencer_multi #(
        .NUM_DOMAINS(1), .HOLDOFF_CYCLES(1), .STEP_CYCLES(1), .SYNC_STAGE(2)
    ) dut_min (
        .clk(clk), .async_reset_n(async_reset_n), .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req2), .domain_reset(domain_reset2),
        .seq_busy(seq_busy2), .seq_done(seq_done2), .last_cause(last_cause2)
    );

    typedef struct {
        int            at_edge;
        logic [VW-1:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_no);
        end
    endtask

    // Reference model: the sequence is described by an anchor edge and arithmetic on
    // elapsed cycles, not by counters.
    typedef enum {K_WAIT, K_RUN, K_SHUT} kind_t;
    kind_t         m_kind   = K_WAIT;
    int            m_anchor = 0;
    logic [1:0]    m_cause  = 2'b00;
    logic          lock_pipe[$];
    logic [VW-1:0] m_last;

    function automatic logic [VW-1:0] expect_at(input int t);
        logic [N-1:0] dr;
        logic         busy, done;
        int           d, r;
        dr   = '1;
        busy = 1'b0;
        done = 1'b0;
        d    = t - m_anchor;
        if (m_kind == K_RUN) begin
            r = (d < H) ? 0 : (d - H) / S;
            if (r > N) r = N;
            for (int k = 0; k < N; k++) dr[k] = (k >= r);
            done = (r == N);
            busy = !done;
        end else if (m_kind == K_SHUT) begin
            r = d / S;
            for (int k = 0; k < N; k++) dr[k] = (k >= N - r);
            busy = 1'b1;
        end
        return {dr, busy, done, m_cause};
    endfunction

    task automatic model_step(input int t);
        logic          ls, was_done;
        logic [VW-1:0] e;
        if (!async_reset_n) begin
            m_kind  = K_WAIT;
            m_cause = 2'b00;
            lock_pipe.delete();
            repeat (SY) lock_pipe.push_back(1'b0);
        end else begin
            if (m_kind == K_SHUT && t - m_anchor >= N * S) begin
                m_kind   = K_RUN;
                m_anchor = m_anchor + N * S;
            end
            was_done = (m_kind == K_RUN) && (t - 1 - m_anchor >= H + N * S);
            ls = lock_pipe.pop_front();
            lock_pipe.push_back(pll_locked);
            if (m_kind != K_WAIT && !ls) begin
                m_kind  = K_WAIT;
                m_cause = 2'b01;
            end else if (m_kind == K_WAIT && ls) begin
                m_kind   = K_RUN;
                m_anchor = t;
            end else if (was_done && sw_reset_req) begin
                m_kind   = K_SHUT;
                m_anchor = t;
                m_cause  = 2'b10;
            end
        end
        e = expect_at(t);
        if (e !== m_last) begin
            sb.push_back('{t, e});
            m_last = e;
        end
    endtask

    initial begin
        m_last = RESET_VEC;
        repeat (SY) lock_pipe.push_back(1'b0);
        forever begin
            @(posedge clk);
            edge_no++;
            model_step(edge_no);
        end
    end

    // Monitor: every change of the observable outputs must match the next queued expectation.
    initial begin
        logic [VW-1:0] prev, cur;
        sb_item_t      it;
        prev = RESET_VEC;
        forever begin
            @(negedge clk);
            cur = {domain_reset, seq_busy, seq_done, last_cause};
            if (cur !== prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", 64'(cur), 64'(prev));
                end else begin
                    it = sb.pop_front();
                    check("change_edge", 64'(edge_no), 64'(it.at_edge));
                    check("change_value", 64'(cur), 64'(it.val));
                end
                prev = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sw();
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
    endtask

    initial begin
        int n0;
        #1 async_reset_n = 1'b0;
        #1;
        check("rst_domain_reset", 64'(domain_reset), 64'(ALL_ON));
        check("rst_busy", 64'(seq_busy), 64'(0));
        check("rst_done", 64'(seq_done), 64'(0));
        check("rst_cause", 64'(last_cause), 64'(0));
        check("rst_min_cause", 64'(last_cause2), 64'(0));

        tick(3);
        async_reset_n = 1'b1;
        pll_locked    = 1'b1;
        n0            = edge_no;

        // Minimal instance: lock seen at n0+3, released two edges later.
        tick(4);
        check("min_dr_before_release", 64'(domain_reset2), 64'(1));
        check("min_done_before_release", 64'(seq_done2), 64'(0));
        tick(1);
        check("min_dr_released", 64'(domain_reset2), 64'(0));
        check("min_done_released", 64'(seq_done2), 64'(1));
        sw_reset_req2 = 1'b1;
        sw_reset_req  = 1'b1;
        tick(1);
        sw_reset_req2 = 1'b0;
        sw_reset_req  = 1'b0;
        check("min_dr_at_req", 64'(domain_reset2), 64'(0));
        check("min_busy_at_req", 64'(seq_busy2), 64'(1));
        tick(1);
        check("min_dr_reasserted", 64'(domain_reset2), 64'(1));
        check("min_done_reasserted", 64'(seq_done2), 64'(0));
        tick(2);
        check("min_dr_rereleased", 64'(domain_reset2), 64'(0));
        check("min_done_rereleased", 64'(seq_done2), 64'(1));

        // Ignored requests in RELEASE, then run to DONE.
        tick(n0 + 3 + H + 50 - edge_no);
        pulse_sw();
        tick(120);

        // Software re-sequence through to DONE again.
        pulse_sw();
        tick(N * S + H + N * S + 20);

        // Lock loss just after domain 0 re-releases, then relock.
        pulse_sw();
        tick(N * S + H + S + 10);
        pll_locked = 1'b0;
        tick(SY + 1);
        check("loss_latency_dr", 64'(domain_reset), 64'(ALL_ON));
        check("loss_latency_cause", 64'(last_cause), 64'(2'b01));
        tick($urandom_range(1, 10));
        pll_locked = 1'b1;
        tick(300);

        // Async reset in the middle of SHUTDOWN.
        pulse_sw();
        tick(S + 8);
        check("mid_shutdown_dr", 64'(domain_reset), 64'(3'b100));
        #2 async_reset_n = 1'b0;
        #1;
        check("async_dr", 64'(domain_reset), 64'(ALL_ON));
        check("async_busy", 64'(seq_busy), 64'(0));
        check("async_done", 64'(seq_done), 64'(0));
        check("async_cause", 64'(last_cause), 64'(0));
        tick(2);
        async_reset_n = 1'b1;
        tick(300);

        // Randomised mix of requests, lock glitches and idle stretches.
        repeat (12) begin
            case ($urandom_range(0, 3))
                0: pulse_sw();
                1: begin
                    pll_locked = 1'b0;
                    tick($urandom_range(1, 6));
                    pll_locked = 1'b1;
                end
                2: tick(H + N * S + 20);
                default: ;
            endcase
            tick($urandom_range(1, 250));
        end

        pll_locked = 1'b1;
        tick(H + N * S + SY + 40);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
